fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit_if.sv | 29 ++
 rtl/fetch_pc_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus between fetch_pc_unit (master) and the
// instruction memory (slave).
//
// Handshake: imem_req is held high, with imem_addr stable, until the memory
// answers. imem_ack qualifies imem_rdata for that one cycle only, and that
// single ack completes the transfer. The master ignores an ack while it is
// not requesting, and imem_rdata is don't-care whenever imem_ack is low.
interface fetch_pc_unit_if #(
  parameter int PC_W = 8
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage.
// The unit fetches a 16-bit word at pc and latches it into the instruction
// register (ir). It presents ir to the decoder for one or more EXEC cycles,
// then advances pc by the decoder's jump/branch decision.
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch-wait timeout. When
// the timeout expires, the unit sets a sticky fetch_err and parks in HALT
// until reset.
module fetch_pc_unit #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_pc_unit_if.master    mem,
  output logic [3:0]         op,
  output logic [15:0]        instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  input  logic               jump,
  input  logic               branch,
  input  logic               stall,
  output logic               fetch_err,
  output logic [1:0]         dbg_state
);

  // A zero or negative timeout would make the wait counter meaningless.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fetch_pc_unit: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
`ifdef FETCH_TIMEOUT_EN
    ,S_HALT = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] br_off;
  logic            fetch_done;
  logic            timeout_hit;

  assign fetch_done = (state_q == S_FETCH) && mem.imem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // The last waiting cycle that is still allowed is wait_cnt == TIMEOUT-1.
  // An ack in that same cycle still counts as a successful fetch.
  assign timeout_hit = (state_q == S_FETCH) && !mem.imem_ack &&
                       (wait_cnt == CW'(TIMEOUT - 1));

  // The wait counter is zero whenever the unit is outside FETCH, so every
  // FETCH starts its count fresh. The error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != S_FETCH) begin
        wait_cnt <= '0;
      end else if (!mem.imem_ack) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE lasts one cycle, FETCH waits for ack, EXEC waits for !stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done) begin
          state_d = S_EXEC;
        end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (!stall) begin
          state_d = S_FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bit-wise build of the jump target and branch offset. The jump target is
  // ir[11:0] truncated or zero-extended to PC_W. The branch offset is ir[7:0]
  // sign-extended, or truncated when PC_W < 8.
  always_comb begin
    jump_tgt = '0;
    br_off   = '0;
    for (int i = 0; i < PC_W; i++) begin
      jump_tgt[i] = (i < 12) ? ir_q[(i < 12) ? i : 0] : 1'b0;
      br_off[i]   = ir_q[(i < 8) ? i : 7];
    end
  end

  // PC successor with priority jump > branch > sequential, all modulo 2^PC_W.
  always_comb begin
    pc_inc = pc_q + PC_W'(1);
    if (jump) begin
      pc_next = jump_tgt;
    end else if (branch) begin
      pc_next = pc_inc + br_off;
    end else begin
      pc_next = pc_inc;
    end
  end

  // ir loads only on an accepted ack. pc moves only when EXEC is released,
  // so a stall freezes both registers and masks jump/branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_W'(RESET_PC);
      ir_q <= 16'h0000;
    end else begin
      if (fetch_done) begin
        ir_q <= mem.imem_rdata;
      end
      if ((state_q == S_EXEC) && !stall) begin
        pc_q <= pc_next;
      end
    end
  end

  assign mem.imem_req  = (state_q == S_FETCH);
  assign mem.imem_addr = pc_q;
  assign instr_valid   = (state_q == S_EXEC);
  assign op            = ir_q[15:12];
  assign instr         = ir_q;
  assign pc            = pc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit (PC_W=8, RESET_PC=0, TIMEOUT=4).
// A hand-computed table covers the directed program. Scripted sequences cover
// async reset and the optional timeout. A random instruction stream is then
// checked against an arithmetic next-pc model.
module tb_fetch_pc_unit;

  localparam int PC_W = 8;

  logic            clk;
  logic            rst_n;
  logic [3:0]      op;
  logic [15:0]     instr;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            jump;
  logic            branch;
  logic            stall;
  logic            fetch_err;
  logic [1:0]      dbg_state;

  fetch_pc_unit_if #(.PC_W(PC_W)) mem_if ();

  fetch_pc_unit #(
    .PC_W(PC_W),
    .RESET_PC(0),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem(mem_if),
    .op(op),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc(pc),
    .jump(jump),
    .branch(branch),
    .stall(stall),
    .fetch_err(fetch_err),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [PC_W-1:0] exp_pc;

  typedef struct {
    logic [15:0]     word;
    int              d;     // ack delay cycles in FETCH
    int              s;     // stall cycles in EXEC
    logic            j;
    logic            b;
    logic [PC_W-1:0] next;  // hand-computed pc after this instruction
  } vec_t;

  vec_t tab[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next pc from the instruction word and the decoder decision.
  // Plain integer arithmetic, reduced modulo 256.
  function automatic logic [PC_W-1:0] model_next(input logic [PC_W-1:0] p,
                                                 input logic [15:0] w,
                                                 input logic j, input logic b);
    int t;
    int off;
    if (j) begin
      t = int'(w[11:0]);
    end else if (b) begin
      off = int'(w[7:0]);
      if (off > 127) off = off - 256;
      t = int'(p) + 1 + off;
    end else begin
      t = int'(p) + 1;
    end
    t = ((t % 256) + 256) % 256;
    return t[PC_W-1:0];
  endfunction

  // One instruction, starting at a negedge with the unit in FETCH.
  // The task holds ack off for d cycles, then acks. It holds EXEC for s
  // stall cycles, then releases EXEC with the given jump/branch.
  task automatic do_instr(input logic [15:0] word, input int d, input int s,
                          input logic j, input logic b,
                          input logic [PC_W-1:0] next, input string tag);
    for (int k = 0; k <= d; k++) begin
      chk({tag, " fetch req"}, 32'(mem_if.imem_req), 32'd1);
      chk({tag, " fetch addr"}, 32'(mem_if.imem_addr), 32'(exp_pc));
      chk({tag, " fetch valid"}, 32'(instr_valid), 32'd0);
      chk({tag, " fetch err"}, 32'(fetch_err), 32'd0);
      mem_if.imem_ack   = (k == d);
      mem_if.imem_rdata = (k == d) ? word : 16'($urandom);
      stall  = 1'($urandom);
      jump   = 1'($urandom);
      branch = 1'($urandom);
      @(negedge clk);
    end
    for (int k = 0; k <= s; k++) begin
      chk({tag, " exec valid"}, 32'(instr_valid), 32'd1);
      chk({tag, " exec op"}, 32'(op), 32'(word[15:12]));
      chk({tag, " exec instr"}, 32'(instr), 32'(word));
      chk({tag, " exec pc"}, 32'(pc), 32'(exp_pc));
      chk({tag, " exec req"}, 32'(mem_if.imem_req), 32'd0);
      // Stray acks with junk data during EXEC must not touch ir.
      mem_if.imem_ack   = 1'($urandom);
      mem_if.imem_rdata = 16'($urandom);
      stall  = (k < s);
      jump   = (k < s) ? 1'b1 : j;
      branch = (k < s) ? 1'($urandom) : b;
      @(negedge clk);
    end
    mem_if.imem_ack = 1'b0;
    stall  = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    exp_pc = next;
  endtask

  // Release reset at a negedge and step through the one IDLE cycle.
  task automatic release_reset(input string tag);
    rst_n = 1'b1;
    #1;
    chk({tag, " idle req"}, 32'(mem_if.imem_req), 32'd0);
    chk({tag, " idle valid"}, 32'(instr_valid), 32'd0);
    mem_if.imem_ack   = 1'b1;
    mem_if.imem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_if.imem_ack   = 1'b0;
    exp_pc = '0;
  endtask

  initial begin
    tab[0]  = '{16'h1000, 0, 0, 1'b0, 1'b0, 8'h01};
    tab[1]  = '{16'h2000, 0, 0, 1'b0, 1'b0, 8'h02};
    tab[2]  = '{16'h3000, 1, 0, 1'b0, 1'b0, 8'h03};
    tab[3]  = '{16'hB010, 0, 0, 1'b1, 1'b0, 8'h10};
    tab[4]  = '{16'h70FC, 0, 0, 1'b0, 1'b1, 8'h0D};
    tab[5]  = '{16'hB010, 0, 0, 1'b1, 1'b0, 8'h10};
    tab[6]  = '{16'h7005, 0, 0, 1'b0, 1'b1, 8'h16};
    tab[7]  = '{16'hC3A7, 0, 0, 1'b1, 1'b1, 8'hA7};
    tab[8]  = '{16'h4A5A, 0, 3, 1'b0, 1'b0, 8'hA8};
    tab[9]  = '{16'h6001, 2, 0, 1'b0, 1'b0, 8'hA9};
    tab[10] = '{16'hB0FF, 2, 1, 1'b1, 1'b0, 8'hFF};
    tab[11] = '{16'h5123, 0, 0, 1'b0, 1'b0, 8'h00};
    tab[12] = '{16'h7080, 1, 0, 1'b0, 1'b1, 8'h81};
    tab[13] = '{16'hE0FE, 0, 0, 1'b0, 1'b1, 8'h80};

    rst_n  = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    stall  = 1'b0;
    mem_if.imem_ack   = 1'b0;
    mem_if.imem_rdata = 16'h0000;
    exp_pc = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst pc", 32'(pc), 32'd0);
    chk("rst addr", 32'(mem_if.imem_addr), 32'd0);
    chk("rst req", 32'(mem_if.imem_req), 32'd0);
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst op", 32'(op), 32'd0);
    chk("rst instr", 32'(instr), 32'd0);
    chk("rst err", 32'(fetch_err), 32'd0);
    release_reset("start");

    // Directed program from the table.
    for (int i = 0; i < 14; i++) begin
      do_instr(tab[i].word, tab[i].d, tab[i].s, tab[i].j, tab[i].b, tab[i].next,
               $sformatf("tab%0d", i));
    end

    // Async reset in the middle of a waiting fetch.
    chk("midrst pre req", 32'(mem_if.imem_req), 32'd1);
    chk("midrst pre addr", 32'(mem_if.imem_addr), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req", 32'(mem_if.imem_req), 32'd0);
    chk("midrst pc", 32'(pc), 32'd0);
    chk("midrst valid", 32'(instr_valid), 32'd0);
    chk("midrst instr", 32'(instr), 32'd0);
    @(negedge clk);
    release_reset("restart");
    do_instr(16'h9001, 0, 0, 1'b0, 1'b0, 8'h01, "restart");

    // Random program against the model.
    for (int n = 0; n < 200; n++) begin
      logic [15:0] w;
      logic        j;
      logic        b;
      w = 16'($urandom);
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), j, b,
               model_next(exp_pc, w, j, b), "rand");
    end

`ifdef FETCH_TIMEOUT_EN
    // No ack ever: four waiting cycles, then HALT with a sticky error.
    rst_n = 1'b0;
    @(negedge clk);
    release_reset("tmo");
    for (int k = 0; k < 4; k++) begin
      chk("tmo wait req", 32'(mem_if.imem_req), 32'd1);
      chk("tmo wait err", 32'(fetch_err), 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk("tmo halt err", 32'(fetch_err), 32'd1);
      chk("tmo halt req", 32'(mem_if.imem_req), 32'd0);
      chk("tmo halt valid", 32'(instr_valid), 32'd0);
      chk("tmo halt pc", 32'(pc), 32'd0);
      mem_if.imem_ack = 1'b1;
      @(negedge clk);
    end
    mem_if.imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("tmo rst err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    release_reset("tmo4");
    // An ack on the fourth waiting cycle is still a success.
    do_instr(16'h8123, 3, 0, 1'b0, 1'b0, 8'h01, "tmo4");
    chk("tmo4 err", 32'(fetch_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
